// File: rtl/systolic_feed_ctrl.sv
// Sequencer for a 4x4 systolic array: loads B weights, skews A rows into the lanes, drains, writes C back.
// Optional busy-cycle counter output perf_cycles when SYSFEED_PERF_CNT_EN is defined.
module systolic_feed_ctrl #(
    parameter int DRAIN_CYC = 4,
    parameter int AW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] b_base,
    input  logic [AW-1:0] c_base,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [AW-1:0] host_data,
    output logic          host_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [AW-1:0] mem_wdata,
    output logic [AW-1:0] mem_raddr1,
    output logic [AW-1:0] mem_raddr2,
    output logic [AW-1:0] mem_raddr3,
    output logic [AW-1:0] mem_raddr4,
    output logic          w_load,
    output logic [1:0]    w_row,
    output logic [3:0]    a_vld,
    output logic [3:0]    res_idx,
    input  logic [AW-1:0] res_data,
    output logic          busy,
    output logic          done
`ifdef SYSFEED_PERF_CNT_EN
    ,
    output logic [31:0]   perf_cycles
`endif
);

    typedef enum logic [2:0] {IDLE, LOADW, FEED, DRAIN, WB, DONE} state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

    state_t              state;
    logic [3:0]          cnt;
    logic [AW-1:0]       a_q, b_q, c_q;
    logic [3:0][AW-1:0]  raddr_q;
    logic                host_wr;

    // Row r of B: four consecutive words starting at base + 4r.
    function automatic logic [3:0][AW-1:0] loadw_addr(input logic [AW-1:0] base, input logic [1:0] r);
        logic [3:0][AW-1:0] res;
        for (int j = 0; j < 4; j++) res[j] = base + AW'(4 * int'(r) + j);
        return res;
    endfunction

    // Lane i is delayed by i cycles so the array sees the skewed wavefront.
    function automatic logic [3:0] feed_vld(input logic [3:0] t);
        logic [3:0] res;
        int         d;
        for (int i = 0; i < 4; i++) begin
            d      = int'(t) - i;
            res[i] = (d >= 0) && (d <= 3);
        end
        return res;
    endfunction

    function automatic logic [3:0][AW-1:0] feed_addr(input logic [AW-1:0] base, input logic [3:0] t);
        logic [3:0][AW-1:0] res;
        logic [3:0]         vld;
        vld = feed_vld(t);
        for (int i = 0; i < 4; i++)
            res[i] = vld[i] ? base + AW'(4 * i + int'(t) - i) : '0;
        return res;
    endfunction

    // NOTE: every register in this block uses <= so all state updates land together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            raddr_q    <= '0;
            w_load     <= 1'b0;
            w_row      <= '0;
            a_vld      <= '0;
            res_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            host_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q        <= a_base;
                        b_q        <= b_base;
                        c_q        <= c_base;
                        state      <= LOADW;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        host_ready <= 1'b0;
                        w_load     <= 1'b1;
                        w_row      <= 2'd0;
                        raddr_q    <= loadw_addr(b_base, 2'd0);
                    end
                end
                LOADW: begin
                    if (cnt == 4'd3) begin
                        state   <= FEED;
                        cnt     <= '0;
                        w_load  <= 1'b0;
                        w_row   <= '0;
                        a_vld   <= feed_vld(4'd0);
                        raddr_q <= feed_addr(a_q, 4'd0);
                    end else begin
                        cnt     <= cnt + 4'd1;
                        w_row   <= cnt[1:0] + 2'd1;
                        raddr_q <= loadw_addr(b_q, cnt[1:0] + 2'd1);
                    end
                end
                FEED: begin
                    if (cnt == 4'd6) begin
                        state   <= DRAIN;
                        cnt     <= '0;
                        a_vld   <= '0;
                        raddr_q <= '0;
                    end else begin
                        cnt     <= cnt + 4'd1;
                        a_vld   <= feed_vld(cnt + 4'd1);
                        raddr_q <= feed_addr(a_q, cnt + 4'd1);
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state   <= WB;
                        cnt     <= '0;
                        res_idx <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WB: begin
                    if (cnt == 4'd15) begin
                        state      <= DONE;
                        cnt        <= '0;
                        res_idx    <= '0;
                        done       <= 1'b1;
                        host_ready <= 1'b1;
                    end else begin
                        cnt     <= cnt + 4'd1;
                        res_idx <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_raddr1 = raddr_q[0];
    assign mem_raddr2 = raddr_q[1];
    assign mem_raddr3 = raddr_q[2];
    assign mem_raddr4 = raddr_q[3];

    // host_ready reads 1 during reset, so the write path is gated by rst_n to keep reset write-free.
    assign host_wr = host_ready & host_we & rst_n;

    // Write port is shared: WB owns it, otherwise an accepted host write passes straight through.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state == WB) begin
            mem_we    = 1'b1;
            mem_waddr = c_q + AW'(res_idx);
            mem_wdata = res_data;
        end else if (host_wr) begin
            mem_we    = 1'b1;
            mem_waddr = host_addr;
            mem_wdata = host_data;
        end
    end

`ifdef SYSFEED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_cycles <= '0;
        else if (busy && (perf_cycles != 32'hFFFF_FFFF))
            perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule
